// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter and master multiplexer for the shared system bus.
//   Four masters raise active-low requests. Exactly one master is granted at
//   all times, and that owner's address, strobe, direction and write data are
//   routed onto the shared bus. An optional hold limit forces rotation
//   between transactions so that a streaming master cannot starve the others.
//
// Parameters
//   HOLD_MAX : consecutive owned cycles before forced rotation (0 = never)
//   CNT_W    : hold counter width, 2**CNT_W > HOLD_MAX
//
// Ports
//   clk, reset            : clock, async active-high reset
//   mN_req_               : master N request (active low)
//   mN_addr/as_/rw/wr_data: master N bus signals
//   mN_grnt_              : master N grant (active low, registered)
//   s_addr/s_as_/s_rw/s_wr_data : shared bus, muxed from the owner
//   owner                 : current owner index (registered)
module bus_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_,
    input  logic        m1_req_,
    input  logic        m2_req_,
    input  logic        m3_req_,
    input  logic [29:0] m0_addr,
    input  logic [29:0] m1_addr,
    input  logic [29:0] m2_addr,
    input  logic [29:0] m3_addr,
    input  logic        m0_as_,
    input  logic        m1_as_,
    input  logic        m2_as_,
    input  logic        m3_as_,
    input  logic        m0_rw,
    input  logic        m1_rw,
    input  logic        m2_rw,
    input  logic        m3_rw,
    input  logic [31:0] m0_wr_data,
    input  logic [31:0] m1_wr_data,
    input  logic [31:0] m2_wr_data,
    input  logic [31:0] m3_wr_data,
    output logic        m0_grnt_,
    output logic        m1_grnt_,
    output logic        m2_grnt_,
    output logic        m3_grnt_,
    output logic [29:0] s_addr,
    output logic        s_as_,
    output logic        s_rw,
    output logic [31:0] s_wr_data,
    output logic [1:0]  owner
);

    logic [3:0]       req_n;
    logic [3:0]       as_n;
    logic [3:0]       grnt_n;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic [1:0]       owner_next;
    logic             own_req_n;
    logic             own_as_n;
    logic             found;
    logic             hold_full;
    logic             do_switch;
    logic [1:0]       cand;

    assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};
    assign as_n  = {m3_as_, m2_as_, m1_as_, m0_as_};

    assign m0_grnt_ = grnt_n[0];
    assign m1_grnt_ = grnt_n[1];
    assign m2_grnt_ = grnt_n[2];
    assign m3_grnt_ = grnt_n[3];

    assign own_req_n = req_n[owner];
    assign own_as_n  = as_n[owner];
    assign hold_full = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX));

    // Round-robin search starting just after the owner; the owner itself is
    // never a candidate, so a switch always moves ownership.
    always_comb begin
        found      = 1'b0;
        owner_next = owner;
        cand       = owner;
        for (int unsigned i = 1; i < 4; i++) begin
            cand = owner + 2'(i);
            if (!found && !req_n[cand]) begin
                found      = 1'b1;
                owner_next = cand;
            end
        end
        // Forced rotation only between transactions (owner's as_ high).
        do_switch = found && (own_req_n || (hold_full && own_as_n));
        if (!do_switch) begin
            owner_next = owner;
        end
    end

    // Saturating hold counter; a strobing owner at the limit simply keeps it
    // saturated until its strobe rises and rotation can happen.
    always_comb begin
        hold_next = hold_cnt;
        if (do_switch || own_req_n) begin
            hold_next = '0;
        end else if (hold_cnt != CNT_W'(HOLD_MAX)) begin
            hold_next = hold_cnt + 1'b1;
        end
    end

    // Grants are registered alongside owner so there is no req_ -> grnt_ path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= '0;
            hold_cnt <= '0;
            grnt_n   <= 4'b1110;
        end else begin
            owner    <= owner_next;
            hold_cnt <= hold_next;
            grnt_n   <= ~(4'b0001 << owner_next);
        end
    end

    // A parked owner that is not requesting cannot strobe the bus.
    always_comb begin
        s_addr    = m0_addr;
        s_rw      = m0_rw;
        s_wr_data = m0_wr_data;
        case (owner)
            2'd1: begin
                s_addr    = m1_addr;
                s_rw      = m1_rw;
                s_wr_data = m1_wr_data;
            end
            2'd2: begin
                s_addr    = m2_addr;
                s_rw      = m2_rw;
                s_wr_data = m2_wr_data;
            end
            2'd3: begin
                s_addr    = m3_addr;
                s_rw      = m3_rw;
                s_wr_data = m3_wr_data;
            end
            default: ;
        endcase
        s_as_ = own_as_n | own_req_n;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter (HOLD_MAX = 4). A behavioural model
//   of owner/hold state is compared against the DUT every falling edge;
//   directed scenarios add literal expectations for reset, single request,
//   round-robin order, hold limit, parking/gating and asynchronous reset.
module tb_bus_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_n [4];
    logic        as_n  [4];
    logic        rw    [4];
    logic [29:0] addr  [4];
    logic [31:0] wd    [4];

    logic        m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [29:0] s_addr;
    logic        s_as_;
    logic        s_rw;
    logic [31:0] s_wr_data;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
        .m0_addr(addr[0]), .m1_addr(addr[1]), .m2_addr(addr[2]), .m3_addr(addr[3]),
        .m0_as_(as_n[0]), .m1_as_(as_n[1]), .m2_as_(as_n[2]), .m3_as_(as_n[3]),
        .m0_rw(rw[0]), .m1_rw(rw[1]), .m2_rw(rw[2]), .m3_rw(rw[3]),
        .m0_wr_data(wd[0]), .m1_wr_data(wd[1]), .m2_wr_data(wd[2]), .m3_wr_data(wd[3]),
        .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] grants();
        return {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    endfunction

    // Behavioural model: who owns the bus and how long it has held it.
    int m_owner = 0;
    int m_hold  = 0;
    int m_next;
    bit m_released, m_forced;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = 0;
            m_hold  = 0;
        end else begin
            m_next = -1;
            for (int d = 1; d < 4; d++) begin
                if (m_next < 0 && req_n[(m_owner + d) % 4] == 1'b0)
                    m_next = (m_owner + d) % 4;
            end
            m_released = req_n[m_owner];
            m_forced   = (HOLD > 0) && (m_hold == HOLD) && as_n[m_owner];
            if (m_next >= 0 && (m_released || m_forced)) begin
                m_owner = m_next;
                m_hold  = 0;
            end else if (m_released) begin
                m_hold = 0;
            end else if (m_hold < HOLD) begin
                m_hold = m_hold + 1;
            end
        end
    end

    // Compare process: everything the DUT drives, every cycle.
    always @(negedge clk) begin
        logic [3:0] eg;
        eg = 4'b1111;
        eg[m_owner] = 1'b0;
        check("owner", 64'(owner), 64'(m_owner));
        check("grants", 64'(grants()), 64'(eg));
        check("s_addr", 64'(s_addr), 64'(addr[m_owner]));
        check("s_rw", 64'(s_rw), 64'(rw[m_owner]));
        check("s_wr_data", 64'(s_wr_data), 64'(wd[m_owner]));
        check("s_as_", 64'(s_as_), 64'(as_n[m_owner] | req_n[m_owner]));
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [3];
        int gc;
        int j;

        for (int i = 0; i < 4; i++) begin
            req_n[i] = 1'b1;
            as_n[i]  = 1'b1;
            rw[i]    = i[0];
            addr[i]  = 30'h100 + 30'(i);
            wd[i]    = 32'hA5A5_0000 + 32'(i);
        end
        addr[2] = 30'h1234;
        reset = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_grants", 64'(grants()), 64'hE);
        check("rst_s_as", 64'(s_as_), 64'd1);
        reset = 1'b0;
        step();
        check("post_rst_grants", 64'(grants()), 64'hE);

        // Single request from master 2
        req_n[2] = 1'b0;
        step();
        check("single_owner", 64'(owner), 64'd2);
        check("single_grants", 64'(grants()), 64'hB);
        check("single_addr", 64'(s_addr), 64'h1234);
        as_n[2] = 1'b0;
        step();
        as_n[2]  = 1'b1;
        req_n[2] = 1'b1;
        req_n[1] = 1'b0;
        step();
        check("to_m1_owner", 64'(owner), 64'd1);

        // Round robin: m1 releases while 0, 2, 3 request
        req_n[1] = 1'b1;
        req_n[0] = 1'b0;
        req_n[2] = 1'b0;
        req_n[3] = 1'b0;
        step();
        for (int n = 0; n < 3; n++) begin
            order[n] = int'(owner);
            j = int'(owner);
            as_n[j] = 1'b0;
            step();
            as_n[j]  = 1'b1;
            req_n[j] = 1'b1;
            step();
        end
        check("rr_first", 64'(order[0]), 64'd2);
        check("rr_second", 64'(order[1]), 64'd3);
        check("rr_third", 64'(order[2]), 64'd0);
        check("rr_park", 64'(owner), 64'd0);

        // Hold limit: m0 streams, m1 waits
        req_n[0] = 1'b0;
        req_n[1] = 1'b0;
        gc = -1;
        for (int c = 0; c < 12; c++) begin
            as_n[0] = (c % 2 == 0) ? 1'b0 : 1'b1;
            step();
            if (owner == 2'd1) begin
                gc = c + 1;
                break;
            end
        end
        check("hold_grant_cycle", 64'(gc), 64'd6);
        as_n[0]  = 1'b1;
        req_n[0] = 1'b1;
        req_n[1] = 1'b1;
        step();
        check("hold_park", 64'(owner), 64'd1);

        // Park and gating with owner 3
        req_n[3] = 1'b0;
        step();
        check("park_owner3", 64'(owner), 64'd3);
        req_n[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            as_n[3] = (k % 2 == 0) ? 1'b0 : 1'b1;
            step();
            check("park_keep", 64'(owner), 64'd3);
            check("park_grnt3", 64'(m3_grnt_), 64'd0);
            check("park_gate", 64'(s_as_), 64'd1);
        end
        as_n[3] = 1'b1;

        // Simultaneous requests resolved relative to owner 3
        req_n[1] = 1'b0;
        req_n[2] = 1'b0;
        step();
        check("simul_owner", 64'(owner), 64'd1);
        req_n[1] = 1'b1;
        step();
        check("simul_next", 64'(owner), 64'd2);

        // Asynchronous reset mid-transaction
        as_n[2] = 1'b0;
        #1;
        check("mid_s_as", 64'(s_as_), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_owner", 64'(owner), 64'd0);
        check("arst_grnt0", 64'(m0_grnt_), 64'd0);
        check("arst_grnt2", 64'(m2_grnt_), 64'd1);
        req_n[2] = 1'b1;
        as_n[2]  = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("final_owner", 64'(owner), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and master multiplexer for the shared system bus. Up to four bus masters (CPU IF port, CPU MEM port, two spare/DMA ports) raise active-low requests. The block grants exactly one of them and routes that owner's address, strobe, direction and write data onto the shared bus. An optional hold limit forces rotation between transactions so a streaming master cannot starve the others.

## Interface
Parameters:
- HOLD_MAX, default 16: maximum consecutive owned cycles before forced rotation when others wait; 0 disables forced rotation.
- CNT_W, default 5: hold counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req_ .. m3_req_  input  1 each  master N bus request, active low.
- m0_addr .. m3_addr  input  30 each  master N word address.
- m0_as_ .. m3_as_  input  1 each  master N address strobe, active low.
- m0_rw .. m3_rw  input  1 each  master N direction (1 = read, 0 = write).
- m0_wr_data .. m3_wr_data  input  32 each  master N write data.
- m0_grnt_ .. m3_grnt_  output  1 each  master N grant, active low, registered.
- s_addr  output  30  shared bus address.
- s_as_  output  1  shared bus address strobe, active low.
- s_rw  output  1  shared bus direction.
- s_wr_data  output  32  shared bus write data.
- owner  output  2  index of the current owner, registered.

## Operation
- State: owner[1:0] and hold_cnt[CNT_W-1:0]. Grants are a registered decode of owner; exactly one m*_grnt_ is low at all times, including the park state.
- Park: with no requests, ownership stays with the last owner. There is no idle owner.
- Re-arbitration is evaluated every cycle. A switch happens at the rising edge when either of these holds:
  - (a) the owner's req_ is high and some other req_ is low, or
  - (b) HOLD_MAX != 0, hold_cnt == HOLD_MAX, the owner's as_ is high (between transactions), and some other req_ is low.
- Next owner: the first master with req_ low, searching owner+1, owner+2, owner+3 modulo 4. The current owner is never re-selected by a switch.
- hold_cnt:
  - Clears to 0 on every owner change.
  - Otherwise increments while the owner's req_ is low, saturating at HOLD_MAX.
  - Clears to 0 while the owner's req_ is high.
- Forced rotation never cuts a transaction. While the owner holds as_ low, rule (b) is suppressed and hold_cnt stays saturated until as_ rises.
- Master obligations: sample grnt_ low before driving as_ low. Keep req_ low for the whole transaction.
- Mux: s_addr, s_rw and s_wr_data are combinationally selected from the owner's inputs. s_as_ equals the owner's as_ ORed with the owner's req_, so a parked, non-requesting owner cannot strobe the bus.
- Unused masters must tie req_ and as_ high.

## Timing
- Reset values: owner = 0, hold_cnt = 0, m0_grnt_ = 0, m1_grnt_/m2_grnt_/m3_grnt_ = 1. Shared-bus outputs follow master 0's inputs, gated as above.
- Grant latency:
  - If requester N's req_ falls in cycle k and the arbiter is switchable, m N_grnt_ falls after the edge ending cycle k. The old owner's grnt_ rises on the same edge.
  - The earliest bus strobe from N is cycle k+1.
- No dead cycle and no overlap at handover: the grnt_ lines are one-hot-low on every cycle.
- Simultaneous requests: resolved by round-robin order relative to the current owner only. Request arrival order is not considered.
- Owner releasing (req_ high) in the same cycle a forced rotation would trigger: handled as rule (a), with the same next-owner search.
- Reset asserted mid-transaction: outputs return to reset values immediately, asynchronously. Any in-flight transaction is abandoned.
- Combinational paths: m*_addr/as_/rw/wr_data/req_ to s_*. The owner/grant outputs are registered, so there is no combinational path from req_ to grnt_.

## Test plan
- Reset: hold reset 3 cycles with all req_ high -> owner=0, m0_grnt_=0, others 1, s_as_=1, hold_cnt=0; release reset, grants unchanged.
- Single request: owner=0 idle, m2_req_ low at cycle 5 -> m2_grnt_=0 and owner=2 from cycle 6; m2_addr=0x1234 appears on s_addr in cycle 6.
- Round robin: owner=1, m1 releases while m0, m2 and m3 all request -> grant order 2, 3, 0, with each master releasing after one transaction.
- Hold limit: HOLD_MAX=4, m0 streams one-cycle transactions with idle gaps, m1 requests at cycle 0 -> m1 granted at the first edge where hold_cnt=4 and m0_as_=1; m0 is never preempted while m0_as_=0.
- Park/gating: owner=3 drops req_ while no one requests -> owner stays 3, m3_grnt_ stays 0, s_as_=1 even if m3_as_ toggles low.
- Reset mid-operation: assert reset while owner=2 and s_as_=0 -> owner=0 and m0_grnt_=0 without waiting for a clock edge; m2_grnt_=1.
